// File: rtl/trigger_delay_multi.sv
// Multi-channel trigger delay: one synchronised, edge-detected trigger fanned
// out to NUM_CH channels, each with its own delay queue, pulse width, enable
// and one-shot/continuous arming.
module trigger_delay_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int WID_W       = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int SYNC_STAGES = 3,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W      = $clog2(QUEUE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger_in,
    input  logic [1:0]        edge_type,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [WID_W-1:0]  cfg_width,
    input  logic              cfg_enable,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] arm,
    input  logic [NUM_CH-1:0] flush,
    output logic [NUM_CH-1:0] trigger_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] armed,
    output logic [NUM_CH-1:0] overflow,
    output logic [CNT_W-1:0]  trig_count
);

    typedef struct packed {
        logic [CNT_W-1:0] delay;
        logic [WID_W-1:0] width;
        logic             enable;
        logic             oneshot;
    } cfg_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   evt_raw;
    logic                   evt_q;
    logic [CNT_W-1:0]       now_q;

    // Edge detection on the synchronised level, selected by edge_type
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        evt_raw = 1'b0;
        unique case (edge_type)
            2'b00:   evt_raw = sync_q[SYNC_STAGES-1] & ~sync_d;
            2'b01:   evt_raw = ~sync_q[SYNC_STAGES-1] & sync_d;
            2'b10:   evt_raw = sync_q[SYNC_STAGES-1] ^ sync_d;
            default: evt_raw = 1'b0;
        endcase
    end

    // Synchroniser chain, edge register and the registered one-cycle event pulse
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_in};
            sync_d <= sync_q[SYNC_STAGES-1];
            evt_q  <= evt_raw;
        end
    end

    // Free-running timestamp and accepted-event counter, both wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q      <= '0;
            trig_count <= '0;
        end else begin
            now_q <= now_q + CNT_W'(1);
            if (evt_q) trig_count <= trig_count + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cfg_t             cfg_q;
        logic             armed_q;
        logic             ovf_q;
        logic             out_q;
        logic [WID_W-1:0] remain_q;
        logic [CNT_W-1:0] mem [QUEUE_DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W:0]   count;
        logic             armed_eff;
        logic             accept;
        logic             full;
        logic             push;
        logic             pop;
        logic [WID_W-1:0] width_eff;

        // Per-channel capture, maturity and pulse-width decisions
        always_comb begin
            armed_eff = armed_q | (arm[c] & cfg_q.oneshot);
            accept    = evt_q & cfg_q.enable & (~cfg_q.oneshot | armed_eff);
            full      = (count == (PTR_W+1)'(QUEUE_DEPTH));
            push      = accept & ~full;
            pop       = (count != '0) && (mem[rd_ptr] == now_q);
            width_eff = (cfg_q.width == '0) ? WID_W'(1) : cfg_q.width;
        end

        // Configuration register; a coincident event still sees the old value
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cfg_q.delay   <= '0;
                cfg_q.width   <= WID_W'(1);
                cfg_q.enable  <= 1'b0;
                cfg_q.oneshot <= 1'b0;
            end else if (cfg_wr && (cfg_ch == CH_W'(c))) begin
                cfg_q.delay   <= cfg_delay;
                cfg_q.width   <= cfg_width;
                cfg_q.enable  <= cfg_enable;
                cfg_q.oneshot <= cfg_oneshot;
            end
        end

        // Arming: arm is applied before capture, a one-shot capture disarms
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                     armed_q <= 1'b0;
            else if (accept && cfg_q.oneshot && !flush[c])  armed_q <= 1'b0;
            else                                            armed_q <= armed_eff;
        end

        // Target storage; the target is the timestamp of the cycle the entry must pop in,
        // one past now+delay because the entry only becomes visible the cycle after capture
        // NOTE: queue storage has no reset; validity is carried entirely by count and the pointers.
        always_ff @(posedge clk) begin
            if (push && !flush[c]) mem[wr_ptr] <= now_q + cfg_q.delay + CNT_W'(1);
        end

        // Queue pointers, occupancy and sticky overflow; flush wins over push and pop
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                ovf_q  <= 1'b0;
            end else if (flush[c]) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                if (accept && full) ovf_q <= 1'b1;
            end
        end

        // Output pulse; a pop during an active pulse reloads the width with no gap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q    <= 1'b0;
                remain_q <= '0;
            end else if (flush[c]) begin
                out_q    <= 1'b0;
                remain_q <= '0;
            end else if (pop) begin
                out_q    <= 1'b1;
                remain_q <= width_eff - WID_W'(1);
            end else if (out_q) begin
                if (remain_q == '0) out_q <= 1'b0;
                else                remain_q <= remain_q - WID_W'(1);
            end
        end

        assign trigger_out[c] = out_q;
        assign busy[c]        = (count != '0) | out_q;
        assign armed[c]       = armed_q;
        assign overflow[c]    = ovf_q;
    end

endmodule

// File: doc/trigger_delay_multi.md
Name: trigger_delay_multi

Overview:
- Multi-channel successor to the single-channel trigger delay path.
- One asynchronous trigger input is synchronised and edge-detected once, then fanned out to NUM_CH independent delay channels.
- Each channel has its own programmable delay, output pulse width, enable and one-shot/continuous mode.
- Each channel holds up to QUEUE_DEPTH in-flight triggers, so a new trigger arriving while an earlier one is still being delayed is not lost.

Parameters:
- NUM_CH, 4, number of independent delay channels (1..16).
- CNT_W, 32, width of the timestamp counter and of the delay field.
- WID_W, 16, width of the pulse-width field.
- QUEUE_DEPTH, 4, pending-trigger entries per channel (power of 2, ≥2).
- SYNC_STAGES, 3, synchroniser flops on trigger_in (≥2).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- trigger_in  in  1  asynchronous trigger pin.
- edge_type  in  2  00 rising, 01 falling, 10 both, 11 disabled.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  channel addressed by cfg_wr.
- cfg_delay  in  CNT_W  delay in clk cycles.
- cfg_width  in  WID_W  output pulse width in cycles; 0 is treated as 1.
- cfg_enable  in  1  channel enable.
- cfg_oneshot  in  1  1 = one-shot mode, 0 = continuous.
- arm  in  NUM_CH  per-channel arm pulse (one-shot mode only).
- flush  in  NUM_CH  per-channel pulse: discard queue, drop output.
- trigger_out  out  NUM_CH  delayed output pulses.
- busy  out  NUM_CH  queue non-empty or pulse active.
- armed  out  NUM_CH  one-shot channel is armed.
- overflow  out  NUM_CH  sticky: trigger dropped on full queue; cleared by flush.
- trig_count  out  CNT_W  accepted edge events (wraps).

Behaviour:
- Reset (rst_n low, async assert, sync release): all outputs 0, queues empty, timestamp counter 0, trig_count 0.
  - Per-channel config resets to delay 0, width 1, enable 0, continuous mode, disarmed.
- Front end: SYNC_STAGES flops followed by one edge register. The internal event pulse is one cycle wide; edge_type 11 produces no event. Each event increments trig_count.
- Timestamp: free-running CNT_W counter, wraps modulo 2^CNT_W.
- Capture on an event in cycle t, per channel: the channel accepts the event if enable=1 and (continuous, or one-shot and armed).
  - Accept: push target = now + delay (mod 2^CNT_W).
  - One-shot accept: clears armed in the same cycle.
  - Queue full: entry dropped, overflow set, armed still cleared.
- Latency: trigger_in level change sampled at clk edge k produces trigger_out high from edge k + SYNC_STAGES + 2 + delay. delay=0 is legal and gives minimum latency.
- Maturity: head entry pops when now equals its target (equality compare, so wrap-safe for any delay < 2^CNT_W). Only the head is checked; entries are in target order because delay is fixed between writes.
- Pulse: on pop, trigger_out goes high for the width latched at pop time.
  - If another entry matures while the pulse is high, the width counter reloads: the output stays high with no gap (retrigger extend).
- Config write: takes effect the cycle after cfg_wr. Queued entries keep their old targets.
  - If cfg_wr and an event occur in the same cycle, the event uses the old config.
  - A delay decrease with entries pending may break target ordering. The channel pops only the head; a later entry whose target has already passed waits for counter wrap. Software must flush when reducing delay.
  - cfg_ch ≥ NUM_CH: write ignored.
- Disable (enable=0): new events are ignored. Pending entries still fire.
- arm: sets armed on a one-shot channel; ignored in continuous mode. arm coincident with an event arms first, then captures.
- flush: the next cycle shows queue empty, trigger_out 0, overflow 0, busy 0. Config and armed are unchanged.
  - flush has priority over a coincident capture and pop on that channel: the coincident event is discarded.
- Reset mid-pulse: trigger_out drops asynchronously; nothing is queued after release.

Test Plan:
- Ch0 delay=10, width=3, rising; rise trigger_in at edge k -> trigger_out[0] high at edges k+15..k+17 only; trig_count=1; other channels silent (disabled).
- Ch1 delay=100, QUEUE_DEPTH=4; 5 rising edges 8 cycles apart -> 4 pulses at 8-cycle spacing, overflow[1]=1, 5th event dropped; flush[1] clears overflow.
- Ch2 delay=0, width=4, both-edge mode; triggers 2 cycles apart -> pulses merge into one continuous high (retrigger extend), busy drops after the last pulse completes.
- Ch3 one-shot, delay=5; 3 triggers without arm -> no output; arm then 3 triggers -> exactly one pulse, armed=0 after the first event.
- Counter wrap: force the timestamp near 2^CNT_W−3, delay=8 -> pulse still at the correct latency across the wrap.
- rst_n low while ch0 has 2 queued entries and a pulse active -> trigger_out=0 immediately; after release no stale pulse appears, config reads back as defaults.
